// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA joystick scanner.
package jamma_pkg;

    typedef enum logic [1:0] {
        P1_SETTLE = 2'd0,
        P1_SAMPLE = 2'd1,
        P2_SETTLE = 2'd2,
        P2_SAMPLE = 2'd3
    } scan_state_e;

    localparam logic [7:0] JOY_IDLE = 8'hFF;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int FIRE1 = 4;
    localparam int FIRE2 = 5;
    localparam int START = 6;
    localparam int COIN  = 7;

    // The on-board stick only covers directions and two buttons.
    function automatic logic [7:0] p1_merge(
        input logic [7:0] bus,
        input logic [5:0] loc
    );
        logic [7:0] m;
        m        = bus;
        m[UP]    = bus[UP] & loc[UP];
        m[DOWN]  = bus[DOWN] & loc[DOWN];
        m[LEFT]  = bus[LEFT] & loc[LEFT];
        m[RIGHT] = bus[RIGHT] & loc[RIGHT];
        m[FIRE1] = bus[FIRE1] & loc[FIRE1];
        m[FIRE2] = bus[FIRE2] & loc[FIRE2];
        m[START] = bus[START];
        m[COIN]  = bus[COIN];
        return m;
    endfunction

endpackage

// File: rtl/jamma_joy_scanner_if.sv
// Pin-side and core-side signals of the JAMMA joystick scanner.
interface jamma_joy_scanner_if;

    logic       ce;
    logic [7:0] jjoy;
    logic [5:0] joy_local;
    logic [1:0] jcoin;
    logic       jselect;
    logic [7:0] joystick1;
    logic [7:0] joystick2;
    logic [1:0] coin_out;
    logic       scan_done;

    modport master (
        output ce, jjoy, joy_local, jcoin,
        input  jselect, joystick1, joystick2, coin_out, scan_done
    );

    modport slave (
        input  ce, jjoy, joy_local, jcoin,
        output jselect, joystick1, joystick2, coin_out, scan_done
    );

endinterface

// File: rtl/joy_debounce.sv
// Per-player debounce: output follows a sample seen DEBOUNCE times in a row.
module joy_debounce
    import jamma_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] sample,
    output logic [7:0] joy
);

    localparam logic [2:0] DB = 3'(DEBOUNCE);

    logic [7:0] cand_q, cand_d;
    logic [7:0] out_q, out_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (en) begin
            if (sample != cand_q) begin
                cand_d = sample;
                cnt_d  = 3'd1;
            end else if (cnt_q < DB) begin
                cnt_d = cnt_q + 3'd1;
            end else begin
                cnt_d = DB;
            end
            if (cnt_d == DB) begin
                out_d = sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= JOY_IDLE;
            cnt_q  <= 3'd0;
            out_q  <= JOY_IDLE;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign joy = out_q;

endmodule

// File: rtl/jamma_joy_scanner.sv
// Sequences the JAMMA joystick-splitter mux, debounces both players
// and turns coin switch edges into fixed-length pulses.
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int DEBOUNCE   = 3,
    parameter int COIN_PULSE = 16
) (
    input logic                pclk,
    input logic                reset,
    jamma_joy_scanner_if.slave bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] PULSE_LEN   = 8'(COIN_PULSE);

    logic [7:0] jjoy_m_q, jjoy_s_q;
    logic [1:0] jcoin_m_q, jcoin_s_q, jcoin_p_q;

    scan_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        jselect_q, jselect_d;
    logic        scan_done_q, scan_done_d;
    logic        p1_en, p2_en;
    logic [7:0]  s1;

    logic [1:0][7:0] coin_cnt_q, coin_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_en       = 1'b0;
        p2_en       = 1'b0;
        scan_done_d = 1'b0;
        if (bus.ce) begin
            unique case (state_q)
                P1_SETTLE, P2_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = (state_q == P1_SETTLE) ? P1_SAMPLE
                                                         : P2_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                P1_SAMPLE: begin
                    p1_en   = 1'b1;
                    state_d = P2_SETTLE;
                end
                P2_SAMPLE: begin
                    p2_en       = 1'b1;
                    scan_done_d = 1'b1;
                    state_d     = P1_SETTLE;
                end
            endcase
        end
        // Decoding the next state lets jselect flip on the entry edge.
        jselect_d = (state_d == P2_SETTLE) || (state_d == P2_SAMPLE);
    end

    always_comb begin
        coin_cnt_d = coin_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (coin_cnt_q[i] != 8'd0) begin
                coin_cnt_d[i] = coin_cnt_q[i] - 8'd1;
            end else if (jcoin_p_q[i] && !jcoin_s_q[i]) begin
                coin_cnt_d[i] = PULSE_LEN;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            jjoy_m_q    <= 8'hFF;
            jjoy_s_q    <= 8'hFF;
            jcoin_m_q   <= 2'b11;
            jcoin_s_q   <= 2'b11;
            jcoin_p_q   <= 2'b11;
            state_q     <= P1_SETTLE;
            cnt_q       <= 4'd0;
            jselect_q   <= 1'b0;
            scan_done_q <= 1'b0;
            coin_cnt_q  <= '0;
        end else begin
            jjoy_m_q    <= bus.jjoy;
            jjoy_s_q    <= jjoy_m_q;
            jcoin_m_q   <= bus.jcoin;
            jcoin_s_q   <= jcoin_m_q;
            jcoin_p_q   <= jcoin_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            jselect_q   <= jselect_d;
            scan_done_q <= scan_done_d;
            coin_cnt_q  <= coin_cnt_d;
        end
    end

    assign s1 = p1_merge(jjoy_s_q, bus.joy_local);

    joy_debounce #(.DEBOUNCE(DEBOUNCE)) u_p1 (
        .clk    (pclk),
        .reset  (reset),
        .en     (p1_en),
        .sample (s1),
        .joy    (bus.joystick1)
    );

    joy_debounce #(.DEBOUNCE(DEBOUNCE)) u_p2 (
        .clk    (pclk),
        .reset  (reset),
        .en     (p2_en),
        .sample (jjoy_s_q),
        .joy    (bus.joystick2)
    );

    assign bus.jselect   = jselect_q;
    assign bus.scan_done = scan_done_q;
    assign bus.coin_out  = {coin_cnt_q[1] == 8'd0, coin_cnt_q[0] == 8'd0};

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Scoreboard bench for jamma_joy_scanner (SETTLE=4, DEBOUNCE=3, COIN_PULSE=16).
module tb_jamma_joy_scanner;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] p1_val = 8'hFF;
    logic [7:0] p2_val = 8'hFF;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;

    ev_t exp1_q[$];
    ev_t exp2_q[$];
    ev_t obs1_q[$];
    ev_t obs2_q[$];
    ev_t drv_q[$];
    int  sel_q[$];
    int  done_q[$];

    jamma_joy_scanner_if bus_if();

    assign bus_if.jjoy = bus_if.jselect ? p2_val : p1_val;

    jamma_joy_scanner #(
        .SETTLE     (4),
        .DEBOUNCE   (3),
        .COIN_PULSE (16)
    ) dut (
        .pclk  (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic find_rise(output int r0, output bit ok);
        logic prev;
        ok   = 1'b0;
        r0   = cyc;
        prev = bus_if.jselect;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.jselect && !prev) begin
                ok = 1'b1;
                r0 = cyc;
            end
            prev = bus_if.jselect;
        end
    endtask

    task automatic watch(input int n);
        logic [7:0] j1, j2;
        ev_t e;
        j1 = bus_if.joystick1;
        j2 = bus_if.joystick2;
        repeat (n) begin
            @(negedge clk);
            if (bus_if.joystick1 !== j1) begin
                e.cyc = cyc;
                e.val = bus_if.joystick1;
                obs1_q.push_back(e);
                j1 = bus_if.joystick1;
            end
            if (bus_if.joystick2 !== j2) begin
                e.cyc = cyc;
                e.val = bus_if.joystick2;
                obs2_q.push_back(e);
                j2 = bus_if.joystick2;
            end
            while (drv_q.size() > 0 && drv_q[0].cyc == cyc) begin
                e      = drv_q.pop_front();
                p1_val = e.val;
            end
        end
    endtask

    task automatic clear_q();
        exp1_q.delete();
        exp2_q.delete();
        obs1_q.delete();
        obs2_q.delete();
        drv_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_if.jselect !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_jselect: got %b want 0", bus_if.jselect);
        end
        n_tests++;
        if (bus_if.joystick1 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_joy1: got %h want ff", bus_if.joystick1);
        end
        n_tests++;
        if (bus_if.joystick2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_joy2: got %h want ff", bus_if.joystick2);
        end
        n_tests++;
        if (bus_if.coin_out !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_coin: got %b want 11", bus_if.coin_out);
        end
        n_tests++;
        if (bus_if.scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 0", bus_if.scan_done);
        end
    endtask

    task automatic test_scan();
        int   rel, want;
        logic prev;
        bit   joy_bad;
        reset = 1'b0;
        rel   = cyc;
        for (int k = 1; k <= 6; k++) sel_q.push_back(rel + 5 * k);
        for (int k = 1; k <= 3; k++) done_q.push_back(rel + 10 * k);
        prev    = 1'b0;
        joy_bad = 1'b0;
        repeat (33) begin
            @(negedge clk);
            if (bus_if.jselect !== prev) begin
                n_tests++;
                want = (sel_q.size() > 0) ? sel_q.pop_front() : -1;
                if (cyc != want) begin
                    n_fail++;
                    $display("FAIL scan_toggle: at cycle %0d want %0d",
                             cyc - rel, want - rel);
                end
                prev = bus_if.jselect;
            end
            if (bus_if.scan_done === 1'b1) begin
                n_tests++;
                want = (done_q.size() > 0) ? done_q.pop_front() : -1;
                if (cyc != want) begin
                    n_fail++;
                    $display("FAIL scan_done: at cycle %0d want %0d",
                             cyc - rel, want - rel);
                end
            end
            if (bus_if.joystick1 !== 8'hFF || bus_if.joystick2 !== 8'hFF)
                joy_bad = 1'b1;
        end
        n_tests++;
        if (sel_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL scan_missing: %0d toggles %0d strobes left, want 0",
                     sel_q.size(), done_q.size());
        end
        n_tests++;
        if (joy_bad) begin
            n_fail++;
            $display("FAIL scan_idle_joy: got a change want ff/ff");
        end
        sel_q.delete();
        done_q.delete();
    endtask

    task automatic test_ce_hold();
        int r0, fall;
        bit ok, bad;
        find_rise(r0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ce_find_rise: got timeout want jselect rise");
        end
        bus_if.ce = 1'b0;
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus_if.jselect !== 1'b1 || bus_if.scan_done !== 1'b0)
                bad = 1'b1;
        end
        bus_if.ce = 1'b1;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL ce_freeze: got activity want frozen");
        end
        fall = -1;
        for (int i = 0; i < 20 && fall < 0; i++) begin
            @(negedge clk);
            if (bus_if.jselect === 1'b0) fall = cyc;
        end
        n_tests++;
        if (fall != r0 + 20) begin
            n_fail++;
            $display("FAIL ce_resume: got fall at +%0d want +20", fall - r0);
        end
    endtask

    task automatic test_p1_debounce();
        int  r0;
        bit  ok;
        ev_t e, o;
        clear_q();
        find_rise(r0, ok);
        p1_val = 8'hFE;
        e.cyc  = r0 + 30;
        e.val  = 8'hFE;
        exp1_q.push_back(e);
        watch(40);
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            n_tests++;
            if (obs1_q.size() == 0) begin
                n_fail++;
                $display("FAIL p1_update: got no change want %h", e.val);
            end else begin
                o = obs1_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL p1_update: got %h at +%0d want %h at +%0d",
                             o.val, o.cyc - r0, e.val, e.cyc - r0);
                end
            end
        end
        n_tests++;
        if (obs1_q.size() != 0 || obs2_q.size() != 0) begin
            n_fail++;
            $display("FAIL p1_extra: got %0d/%0d extra changes want 0",
                     obs1_q.size(), obs2_q.size());
        end
    endtask

    task automatic test_glitch();
        int  r0;
        bit  ok;
        ev_t e, o;
        clear_q();
        find_rise(r0, ok);
        p1_val = 8'hFB;
        e.cyc  = r0 + 10;
        e.val  = 8'hFF;
        drv_q.push_back(e);
        e.cyc  = r0 + 20;
        e.val  = 8'hFB;
        drv_q.push_back(e);
        e.cyc  = r0 + 50;
        e.val  = 8'hFB;
        exp1_q.push_back(e);
        watch(60);
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            n_tests++;
            if (obs1_q.size() == 0) begin
                n_fail++;
                $display("FAIL glitch_update: got no change want %h", e.val);
            end else begin
                o = obs1_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL glitch_update: got %h at +%0d want %h at +%0d",
                             o.val, o.cyc - r0, e.val, e.cyc - r0);
                end
            end
        end
        n_tests++;
        if (obs1_q.size() != 0 || obs2_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_extra: got %0d/%0d extra changes want 0",
                     obs1_q.size(), obs2_q.size());
        end
    endtask

    task automatic test_local();
        int  r0;
        bit  ok;
        ev_t e, o;
        clear_q();
        find_rise(r0, ok);
        p1_val           = 8'hFF;
        bus_if.joy_local = 6'b111101;
        e.cyc = r0 + 30;
        e.val = 8'hFD;
        exp1_q.push_back(e);
        watch(40);
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            n_tests++;
            if (obs1_q.size() == 0) begin
                n_fail++;
                $display("FAIL local_update: got no change want %h", e.val);
            end else begin
                o = obs1_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL local_update: got %h at +%0d want %h at +%0d",
                             o.val, o.cyc - r0, e.val, e.cyc - r0);
                end
            end
        end
        n_tests++;
        if (obs1_q.size() != 0 || obs2_q.size() != 0) begin
            n_fail++;
            $display("FAIL local_extra: got %0d/%0d extra changes want 0",
                     obs1_q.size(), obs2_q.size());
        end
    endtask

    task automatic test_p2();
        int  r0;
        bit  ok;
        ev_t e, o;
        clear_q();
        find_rise(r0, ok);
        p2_val = 8'h7F;
        e.cyc  = r0 + 25;
        e.val  = 8'h7F;
        exp2_q.push_back(e);
        watch(35);
        while (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            n_tests++;
            if (obs2_q.size() == 0) begin
                n_fail++;
                $display("FAIL p2_update: got no change want %h", e.val);
            end else begin
                o = obs2_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL p2_update: got %h at +%0d want %h at +%0d",
                             o.val, o.cyc - r0, e.val, e.cyc - r0);
                end
            end
        end
        n_tests++;
        if (obs1_q.size() != 0 || obs2_q.size() != 0) begin
            n_fail++;
            $display("FAIL p2_extra: got %0d/%0d extra changes want 0",
                     obs1_q.size(), obs2_q.size());
        end
    endtask

    task automatic test_coin();
        int c0, first, last, lowcnt;
        bit bad1;
        @(negedge clk);
        c0           = cyc;
        bus_if.jcoin = 2'b10;
        first  = -1;
        last   = -1;
        lowcnt = 0;
        bad1   = 1'b0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (bus_if.coin_out[0] === 1'b0) begin
                if (first < 0) first = cyc;
                last = cyc;
                lowcnt++;
            end
            if (bus_if.coin_out[1] !== 1'b1) bad1 = 1'b1;
            if (i == 8) bus_if.jcoin = 2'b11;
            if (i == 10) bus_if.jcoin = 2'b10;
        end
        bus_if.jcoin = 2'b11;
        n_tests++;
        if (first != c0 + 3) begin
            n_fail++;
            $display("FAIL coin_start: got +%0d want +3", first - c0);
        end
        n_tests++;
        if (lowcnt != 16) begin
            n_fail++;
            $display("FAIL coin_len: got %0d want 16", lowcnt);
        end
        n_tests++;
        if (last != c0 + 18) begin
            n_fail++;
            $display("FAIL coin_end: got +%0d want +18", last - c0);
        end
        n_tests++;
        if (bad1) begin
            n_fail++;
            $display("FAIL coin_other: got coin_out[1] low want high");
        end
    endtask

    task automatic test_reset_mid();
        int r0, rel, rise;
        bit ok;
        repeat (5) @(negedge clk);
        find_rise(r0, ok);
        bus_if.jcoin = 2'b01;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_if.coin_out !== 2'b01 || bus_if.jselect !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got coin %b sel %b want 01 1",
                     bus_if.coin_out, bus_if.jselect);
        end
        reset        = 1'b1;
        bus_if.jcoin = 2'b11;
        @(negedge clk);
        n_tests++;
        if (bus_if.jselect !== 1'b0 || bus_if.coin_out !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_ctl: got sel %b coin %b want 0 11",
                     bus_if.jselect, bus_if.coin_out);
        end
        n_tests++;
        if (bus_if.joystick1 !== 8'hFF || bus_if.joystick2 !== 8'hFF ||
            bus_if.scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_joy: got %h %h %b want ff ff 0",
                     bus_if.joystick1, bus_if.joystick2, bus_if.scan_done);
        end
        reset = 1'b0;
        rel   = cyc;
        rise  = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            @(negedge clk);
            if (bus_if.jselect === 1'b1) rise = cyc;
        end
        n_tests++;
        if (rise != rel + 5) begin
            n_fail++;
            $display("FAIL rst_rescan: got rise at +%0d want +5", rise - rel);
        end
    endtask

    initial begin
        bus_if.ce        = 1'b1;
        bus_if.joy_local = 6'h3F;
        bus_if.jcoin     = 2'b11;
        test_reset();
        test_scan();
        test_ce_hold();
        test_p1_debounce();
        test_glitch();
        test_local();
        test_p2();
        test_coin();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jamma_joy_scanner.md
Name: jamma_joy_scanner

Overview:
- Sequences the JAMMA joystick-splitter multiplexer.
  - Drives the external select line.
  - Waits a settle time after each select change.
  - Samples the shared 8-bit JJOY bus per player.
  - Debounces each player's sample.
  - Presents stable active-low joystick1/joystick2 to the arcade core.
- Also conditions the two coin inputs: synchronise, then emit fixed-length pulses.
- Sits between the top-level JAMMA pins and the game core, in place of a free-running select toggle.

Parameters:
- SETTLE, 4, ce-qualified cycles to wait after a select change before sampling; legal range 2..15.
- DEBOUNCE, 3, consecutive identical samples of one player needed to update that player's output; legal range 1..7.
- COIN_PULSE, 16, pclk cycles a coin output stays low per accepted coin edge; legal range 1..255.

Ports:
- pclk  in  1  core pixel clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- ce  in  1  scan-rate enable; the FSM and counters advance only when ce=1.
- jjoy  in  8  raw shared JAMMA bus, active-low, asynchronous.
- joy_local  in  6  on-board joystick, active-low; ANDed into player 1 bits [5:0].
- jcoin  in  2  raw coin switches, active-low, asynchronous.
- jselect  out  1  mux select: 0 = player 1 bank, 1 = player 2 bank.
- joystick1  out  8  debounced player 1 {start, btn, dirs}, active-low.
- joystick2  out  8  debounced player 2, active-low.
- coin_out  out  2  coin pulses, active-low.
- scan_done  out  1  one-pclk strobe after each player 2 sample.

Behaviour:
- Reset values: jselect=0, joystick1=joystick2=8'hFF, coin_out=2'b11, scan_done=0. FSM in P1_SETTLE, all counters 0, debounce candidates 8'hFF.
- Input synchronisers:
  - jjoy and jcoin each pass through 2-flop synchronisers (reset to all-ones).
  - SETTLE>=2 covers the synchroniser latency.
- FSM states:
  - P1_SETTLE: jselect=0. Count ce cycles; after SETTLE of them go to P1_SAMPLE.
  - P1_SAMPLE: one ce cycle. Sample s1 = jjoy_sync & {2'b11, joy_local}. Run the debounce step for P1. Go to P2_SETTLE.
  - P2_SETTLE: jselect=1. Count SETTLE ce cycles, then go to P2_SAMPLE.
  - P2_SAMPLE: one ce cycle. Sample s2 = jjoy_sync. Run the debounce step for P2. Pulse scan_done on the next pclk. Go to P1_SETTLE.
- Timing:
  - jselect is a registered decode of state; it changes on the edge entering a SETTLE state.
  - With ce tied high, jselect toggles every SETTLE+1 cycles.
  - A full frame is 2*(SETTLE+1) ce cycles.
- Debounce step, per player, with candidate register cand and 3-bit cnt:
  - If sample != cand: cand<=sample, cnt<=1.
  - Else: cnt<=min(cnt+1, DEBOUNCE).
  - The output register is loaded with sample when the updated cnt equals DEBOUNCE.
  - With DEBOUNCE=1, every sample passes straight through.
  - The output changes one pclk after the sample cycle.
- ce=0 freezes the FSM, counters and jselect. Coin logic is unaffected by ce.
- Coin channel, independent per bit, counter width 8:
  - A falling edge of jcoin_sync (1→0) while the counter is 0 loads COIN_PULSE and drives coin_out low starting on the next pclk.
  - The counter decrements every pclk; coin_out returns high when it reaches 0.
  - Exactly COIN_PULSE low cycles per accepted coin.
  - Edges that occur while the counter is nonzero are ignored (no retrigger, no extension).
  - A coin held low produces one pulse only.
- Reset asserted mid-frame or mid-pulse returns everything to reset values on the next edge. Scanning restarts at P1_SETTLE.

Decomposition:
- Shared package `jamma_pkg`:
  - FSM state encoding (2-bit: P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE).
  - JOY_IDLE=8'hFF.
  - Bit-index constants (UP, DOWN, LEFT, RIGHT, FIRE1, FIRE2, START, COIN).
- One sub-module: `joy_debounce` (8-bit candidate, counter, output register). Instantiated twice.
- The coin pulser stays inline.

Test Plan:
- Reset then ce=1, jjoy=8'hFF: jselect toggles 0→1 after 5 cycles, then period 10. Outputs stay 8'hFF. scan_done pulses once per 10 cycles.
- Drive jjoy=8'hFE only while jselect=0, otherwise 8'hFF: joystick1 becomes 8'hFE one cycle after the 3rd P1 sample. joystick2 stays 8'hFF.
- Glitch: P1 samples 8'hFB, 8'hFF, 8'hFB, 8'hFB, 8'hFB: joystick1 updates only after the 5th sample. No intermediate change.
- joy_local=6'b111101 with jjoy=8'hFF: joystick1 settles to 8'hFD. joystick2 is unaffected.
- jcoin[0] falls and stays low for 100 cycles: coin_out[0] is low for exactly 16 cycles, starting 3 pclk after the input edge. A second fall within the pulse is ignored. coin_out[1] stays high.
- Reset asserted during P2_SETTLE with coin pulse active: the next edge gives jselect=0, coin_out=2'b11, outputs 8'hFF. Re-scan produces first jselect rise 5 ce cycles after reset release.
